// File: rtl/pi_dpd_packer_if.sv
// Digit-in / word-out bundle for the DPD packer.
// master: digit producer and write-port observer; slave: the packer itself.
// N sets the memory word-address width.
interface pi_dpd_packer_if #(parameter int N = 17);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_digit;
  logic          in_last;
  logic          mem_we;
  logic [N-1:0]  mem_addr;
  logic [35:0]   mem_d;
  logic          done;
  logic          err;

  modport master (
    output in_valid, in_digit, in_last,
    input  in_ready, mem_we, mem_addr, mem_d, done, err
  );

  modport slave (
    input  in_valid, in_digit, in_last,
    output in_ready, mem_we, mem_addr, mem_d, done, err
  );
endinterface

// File: rtl/pi_dpd_packer.sv
// Packs BCD digits three at a time into DPD declets and emits the little-endian declet stream as 36-bit words.
// Latency: group-completing digit in cycle t -> declet t+1 -> word write t+2; flush t+3, done t+4 after last digit.
// Backpressure: in_ready=0 from the last digit until done. Macro PI_PACK_CHECK_EN enables the digit range check / err.
module pi_dpd_packer #(
  parameter int N = 17
) (
  input  logic           clk,
  input  logic           rst,
  pi_dpd_packer_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAD   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [N-1:0] ADDR_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t        state;
  logic          in_ready_q;
  logic          done_q;

  // Group assembly: first digit is the hundreds digit, second the tens.
  logic [3:0]    slot_h;
  logic [3:0]    slot_t;
  logic [1:0]    slot_idx;

  // Encoded declet waiting to be appended to the bit buffer.
  logic [9:0]    dec;
  logic          dec_vld;

  // Bit buffer holds fewer than 36 valid bits between appends.
  logic [45:0]   bit_buf;
  logic [5:0]    fill;
  logic [N-1:0]  wr_ptr;

  logic          mem_we_q;
  logic [N-1:0]  mem_addr_q;
  logic [35:0]   mem_d_q;
  logic          err_q;

  logic          take;
  logic          pad_step;
  logic          step;
  logic          grp_done;
  logic [3:0]    dig_raw;
  logic [3:0]    dig_in;
  logic [45:0]   app_buf;
  logic [5:0]    app_cnt;
  logic          app_full;
  logic          flush_go;

  // IEEE 754-2008 DPD encoding; h/t/o are the hundreds/tens/ones BCD digits.
  function automatic logic [9:0] dpd_enc(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    logic [9:0] r;
    case ({h[3], t[3], o[3]})
      3'b000:  r = {h[2:0], t[2:0], 1'b0, o[2:0]};
      3'b001:  r = {h[2:0], t[2:0], 3'b100, o[0]};
      3'b010:  r = {h[2:0], o[2:1], t[0], 3'b101, o[0]};
      3'b100:  r = {o[2:1], h[0], t[2:0], 3'b110, o[0]};
      3'b110:  r = {o[2:1], h[0], 2'b00, t[0], 3'b111, o[0]};
      3'b101:  r = {t[2:1], h[0], 2'b01, t[0], 3'b111, o[0]};
      3'b011:  r = {h[2:0], 2'b10, t[0], 3'b111, o[0]};
      default: r = {2'b00, h[0], 2'b11, t[0], 3'b111, o[0]};
    endcase
    return r;
  endfunction

  // Select the digit entering the group (real input or a pad zero) and form the append result.
  always_comb begin
    take     = (state == RUN) && bus.in_valid && in_ready_q;
    pad_step = (state == PAD);
    step     = take || pad_step;
    grp_done = step && (slot_idx == 2'd2);
    dig_raw  = pad_step ? 4'd0 : bus.in_digit;
`ifdef PI_PACK_CHECK_EN
    dig_in   = (take && (bus.in_digit > 4'd9)) ? 4'd0 : dig_raw;
`else
    dig_in   = dig_raw;
`endif
    app_buf  = bit_buf | ({36'd0, dec} << fill);
    app_cnt  = fill + 6'd10;
    app_full = (app_cnt >= 6'd36);
    flush_go = (state == FLUSH) && !dec_vld;
  end

  // Fill the hundreds and tens slots; the third digit completes the group.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_h   <= 4'd0;
      slot_t   <= 4'd0;
      slot_idx <= 2'd0;
    end else if (step) begin
      if (slot_idx == 2'd2) begin
        slot_idx <= 2'd0;
      end else begin
        if (slot_idx == 2'd0) slot_h <= dig_in;
        else                  slot_t <= dig_in;
        slot_idx <= slot_idx + 2'd1;
      end
    end
  end

  // Register the declet one cycle after its group completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec     <= 10'd0;
      dec_vld <= 1'b0;
    end else begin
      dec_vld <= grp_done;
      if (grp_done) dec <= dpd_enc(slot_h, slot_t, dig_in);
    end
  end

  // Append declets to the buffer, emit full words, and write the partial tail word on flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_buf    <= 46'd0;
      fill       <= 6'd0;
      wr_ptr     <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_d_q    <= 36'd0;
    end else begin
      mem_we_q <= 1'b0;
      if (state == DONE) begin
        bit_buf <= 46'd0;
        fill    <= 6'd0;
        wr_ptr  <= '0;
      end else if (dec_vld) begin
        if (app_full) begin
          mem_we_q   <= 1'b1;
          mem_addr_q <= wr_ptr;
          mem_d_q    <= app_buf[35:0];
          wr_ptr     <= wr_ptr + ADDR_ONE;
          bit_buf    <= app_buf >> 36;
          fill       <= app_cnt - 6'd36;
        end else begin
          bit_buf <= app_buf;
          fill    <= app_cnt;
        end
      end else if (flush_go && (fill != 6'd0)) begin
        // Bits above fill are already zero, so the tail word needs no masking.
        mem_we_q   <= 1'b1;
        mem_addr_q <= wr_ptr;
        mem_d_q    <= bit_buf[35:0];
        wr_ptr     <= wr_ptr + ADDR_ONE;
        bit_buf    <= 46'd0;
        fill       <= 6'd0;
      end
    end
  end

  // Image sequencing: accept digits, pad the last group, wait for the tail write, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        RUN: begin
          if (take && bus.in_last) begin
            in_ready_q <= 1'b0;
            state      <= (slot_idx == 2'd2) ? FLUSH : PAD;
          end
        end
        PAD: begin
          if (slot_idx == 2'd2) state <= FLUSH;
        end
        FLUSH: begin
          if (!dec_vld) state <= DONE;
        end
        default: begin
          done_q     <= 1'b1;
          in_ready_q <= 1'b1;
          state      <= RUN;
        end
      endcase
    end
  end

`ifdef PI_PACK_CHECK_EN
  // Sticky out-of-range flag, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst)                               err_q <= 1'b0;
    else if (take && (bus.in_digit > 4'd9)) err_q <= 1'b1;
  end
`else
  assign err_q = 1'b0;
`endif

  assign bus.in_ready = in_ready_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_d    = mem_d_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule
